alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command front-end for the 32-bit ALU (operands num1/num2, command cm, mode temp; outputs num3 and 4-bit flags FL).
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Issues each operation to the ALU, holds the operands stable for a settle window, then captures num3/FL.
- Presents the captured result downstream with valid/ready, so the ALU is driven one operation at a time from a clocked pipeline.

Parameters:
- DW, 32, operand/result width.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- SETTLE, 1, cycles operands are held on the ALU before capture; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_a  in  DW  operand A.
- req_b  in  DW  operand B.
- req_cm  in  4  ALU command.
- req_temp  in  2  ALU mode bits.
- alu_num1  out  DW  to ALU num1.
- alu_num2  out  DW  to ALU num2.
- alu_cm  out  4  to ALU cm.
- alu_temp  out  2  to ALU temp.
- alu_num3  in  DW  ALU result.
- alu_fl  in  4  ALU flags.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  DW  captured num3.
- rsp_flags  out  4  captured FL.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (synchronous, active-high; same-cycle rst overrides everything):
  - FIFO empty, FSM in IDLE, settle counter 0.
  - All alu_* outputs 0; rsp_valid 0; rsp_result 0; rsp_flags 0; busy 0.
  - req_ready is 1 on the first cycle after reset.
  - rst mid-operation discards the FIFO contents and any in-flight or held result; no response is emitted.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full; it does not look ahead at a same-cycle pop.
  - Pop only on the IDLE→DRIVE transition.
  - A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into alu_num1/alu_num2/alu_cm/alu_temp registers, load counter = SETTLE-1, go to DRIVE. Otherwise stay.
  - DRIVE: alu_* held constant. If counter==0, go to CAPTURE; else decrement.
  - CAPTURE: register alu_num3→rsp_result and alu_fl→rsp_flags; set rsp_valid; go to HOLD.
  - HOLD: rsp_valid=1; result and flags stable. On rsp_ready, clear rsp_valid and go to IDLE.
- alu_* registers keep their last value after an operation completes; they are not cleared.
- Latency: request accepted into an empty FIFO at edge N → rsp_valid high at edge N+SETTLE+3 (one edge each to pop, capture, and the extra IDLE cycle).
- Throughput: with rsp_ready tied high, one result every SETTLE+3 cycles.
- Backpressure: rsp_ready low stalls in HOLD; the FIFO keeps accepting until full.
- No arithmetic is performed in the block; cm/temp pass through unmodified, including unused codes.

Optional Feature:
- Macro ALU_STICKY_FLAGS_EN.
- Defined:
  - Adds input clr_sticky (1) and output sticky_flags (4).
  - On each CAPTURE, sticky_flags |= alu_fl.
  - clr_sticky zeroes sticky_flags. If clr_sticky and CAPTURE occur in the same cycle, the result is alu_fl only (clear, then OR).
  - Reset value 0.
- Undefined: neither port exists; no flag accumulation logic.

Decomposition:
- Package alu_seq_pkg:
  - State enum {IDLE, DRIVE, CAPTURE, HOLD}.
  - CM_W=4, TEMP_W=2, FL_W=4.
  - Packed request struct {a, b, cm, temp}.
- Sub-module alu_req_fifo: synchronous FIFO of the request struct, parameterised by DEPTH, with full/empty/count.

Test Plan:
- Reset then a single request a=32'h00011, b=32'h00101, cm=0, temp=0, with the bench ALU model num3=num1+num2, FL={Z,N,C,V}:
  - alu_num1=32'h00011 and alu_num2=32'h00101 are stable for SETTLE cycles.
  - rsp_result=32'h00112, rsp_flags=4'b0000.
  - rsp_valid rises exactly SETTLE+3 edges after acceptance.
- Back-to-back stream cm=0,1,2,3,4,10,12 with the same operands, rsp_ready=1: seven responses in order, each matching the model output for its cm; consecutive rsp_valid pulses spaced SETTLE+3 cycles apart.
- rsp_ready held low while pushing 6 requests (DEPTH=4):
  - req_ready drops after the 5th accepted request (4 in FIFO plus 1 in the FSM).
  - The 6th request waits with req_valid held.
  - Releasing rsp_ready drains all six in order.
- Assert rst during DRIVE with 3 requests queued: the next cycle shows all outputs 0 and busy=0; no rsp_valid is ever emitted for the discarded requests.
- Simultaneous push and pop with the FIFO at 3/4 full: count stays at 3 and req_ready stays 1. Pointer wrap verified across 10 or more requests.
- With ALU_STICKY_FLAGS_EN: captures with FL=4'b0001 then 4'b1000 give sticky_flags=4'b1001; clr_sticky in the same cycle as a capture of 4'b0100 gives 4'b0100.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and widths for the ALU command sequencer.
//   state_t   : sequencer FSM states
//   CM_W/TEMP_W/FL_W : ALU command, mode and flag widths
//   CNT_W     : settle counter width (SETTLE up to 15)
//   alu_req_t : default request entry {a, b, cm, temp} at the 32-bit ALU width
package alu_seq_pkg;

  localparam int ALU_DW = 32;
  localparam int CM_W   = 4;
  localparam int TEMP_W = 2;
  localparam int FL_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic [CM_W-1:0]   cm;
    logic [TEMP_W-1:0] temp;
  } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous first-word-fall-through FIFO of request entries.
//   clk, rst       : clock, synchronous active-high reset
//   push, wdata    : write strobe / entry (ignored when full)
//   pop, rdata     : read strobe (ignored when empty) / head entry
//   full, empty    : occupancy flags
//   count          : entries held, $clog2(DEPTH)+1 bits
module alu_req_fifo
  import alu_seq_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = alu_req_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the 32-bit ALU.
// Buffers requests, drives one operation at a time onto the ALU, holds the
// operands for SETTLE cycles, captures num3/FL and offers them downstream.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready, req_*    : request handshake and payload
//   alu_num1/num2/cm/temp         : registered drive to the ALU
//   alu_num3, alu_fl              : ALU result and flags
//   rsp_valid/rsp_ready, rsp_*    : captured result handshake
//   busy                          : work queued or in flight
// Optional ALU_STICKY_FLAGS_EN adds clr_sticky (in) and sticky_flags (out),
// an OR-accumulation of every captured flag set.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DW-1:0]     req_a,
  input  logic [DW-1:0]     req_b,
  input  logic [CM_W-1:0]   req_cm,
  input  logic [TEMP_W-1:0] req_temp,
  output logic [DW-1:0]     alu_num1,
  output logic [DW-1:0]     alu_num2,
  output logic [CM_W-1:0]   alu_cm,
  output logic [TEMP_W-1:0] alu_temp,
  input  logic [DW-1:0]     alu_num3,
  input  logic [FL_W-1:0]   alu_fl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_result,
  output logic [FL_W-1:0]   rsp_flags,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic              clr_sticky,
  output logic [FL_W-1:0]   sticky_flags,
`endif
  output logic              busy
);

  typedef struct packed {
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic [CM_W-1:0]   cm;
    logic [TEMP_W-1:0] temp;
  } req_t;

  req_t                   fifo_wdata, fifo_head;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]          num1_q, num1_d, num2_q, num2_d;
  logic [CM_W-1:0]        cm_q, cm_d;
  logic [TEMP_W-1:0]      temp_q, temp_d;
  logic [DW-1:0]          result_q, result_d;
  logic [FL_W-1:0]        flags_q, flags_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   fifo_seen_q;
  logic                   start;

  assign fifo_wdata = '{a: req_a, b: req_b, cm: req_cm, temp: req_temp};

  alu_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // IDLE acts on a one-cycle-old view of occupancy; this is the extra IDLE
  // cycle in the request-to-response latency. The live empty flag still
  // gates the pop so a stale view can never pop an empty FIFO.
  assign start = (state_q == IDLE) && fifo_seen_q && !fifo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (cnt_q == '0) state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    fifo_pop    = 1'b0;
    cnt_d       = cnt_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    cm_d        = cm_q;
    temp_d      = temp_q;
    result_d    = result_q;
    flags_d     = flags_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          fifo_pop = 1'b1;
          num1_d   = fifo_head.a;
          num2_d   = fifo_head.b;
          cm_d     = fifo_head.cm;
          temp_d   = fifo_head.temp;
          cnt_d    = CNT_W'(SETTLE - 1);
        end
      end
      DRIVE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        result_d    = alu_num3;
        flags_d     = alu_fl;
        rsp_valid_d = 1'b1;
      end
      HOLD: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      cm_q        <= '0;
      temp_q      <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 1'b0;
      fifo_seen_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      cm_q        <= cm_d;
      temp_q      <= temp_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
      fifo_seen_q <= !fifo_empty;
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic [FL_W-1:0] sticky_q, sticky_d;

  // Clear first, then OR, so a clear coinciding with a capture keeps that
  // capture's flags.
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    if (state_q == CAPTURE) sticky_d = sticky_d | alu_fl;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

  assign req_ready  = !fifo_full;
  assign alu_num1   = num1_q;
  assign alu_num2   = num2_q;
  assign alu_cm     = cm_q;
  assign alu_temp   = temp_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign busy       = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer with a
// behavioural ALU model and an expected-result scoreboard.
module tb_alu_op_sequencer;

  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [DW-1:0] req_a, req_b;
  logic [3:0]    req_cm;
  logic [1:0]    req_temp;
  logic [DW-1:0] alu_num1, alu_num2, alu_num3;
  logic [3:0]    alu_cm, alu_fl;
  logic [1:0]    alu_temp;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic          busy;
`ifdef ALU_STICKY_FLAGS_EN
  logic          clr_sticky;
  logic [3:0]    sticky_flags;
`endif

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int n_rsp = 0;
  logic [DW+3:0] exp_q [$];
  int            rsp_cyc [$];
  logic [DW+3:0] e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.DW(DW), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cm(req_cm), .req_temp(req_temp),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_cm(alu_cm), .alu_temp(alu_temp),
    .alu_num3(alu_num3), .alu_fl(alu_fl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
`ifdef ALU_STICKY_FLAGS_EN
    .clr_sticky(clr_sticky), .sticky_flags(sticky_flags),
`endif
    .busy(busy)
  );

  // Bench ALU: result in [DW+3:4], flags {Z,N,C,V} in [3:0]. temp is XORed
  // into the result so mode bits are observable; cm 15 returns b[3:0] as
  // flags to allow arbitrary flag patterns.
  function automatic logic [DW+3:0] alu_model(input logic [DW-1:0] a,
      input logic [DW-1:0] b, input logic [3:0] cm, input logic [1:0] temp);
    logic [DW:0]   w;
    logic [DW-1:0] r;
    logic          c, v;
    logic [3:0]    f;
    w = '0; c = 1'b0; v = 1'b0;
    case (cm)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[DW-1:0]; c = w[DW];
                  v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[DW-1:0]; c = w[DW];
                  v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd10:   r = a << b[4:0];
      4'd12:   r = ~a;
      default: r = a;
    endcase
    r = r ^ {{(DW-2){1'b0}}, temp};
    f = {(r == '0), r[DW-1], c, v};
    if (cm == 4'd15) f = b[3:0];
    return {r, f};
  endfunction

  assign {alu_num3, alu_fl} = alu_model(alu_num1, alu_num2, alu_cm, alu_temp);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_req(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [3:0] cm, input logic [1:0] temp);
    int t;
    req_a = a; req_b = b; req_cm = cm; req_temp = temp; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 200) begin step(); t++; end
    if (t >= 200) chk("push_timeout", 1, 0);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && t < 400) begin step(); t++; end
    chk("drain_done", (exp_q.size() == 0 && !busy && !rsp_valid), 1);
  endtask

  task automatic wait_rsp_valid();
    int t;
    t = 0;
    while (!rsp_valid && t < 100) begin step(); t++; end
    chk("wait_rsp_valid", rsp_valid, 1);
  endtask

  // Scoreboard: record expectations at request handshake, compare at
  // response handshake; reset discards anything outstanding.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (req_valid && req_ready)
        exp_q.push_back(alu_model(req_a, req_b, req_cm, req_temp));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e[DW+3:4]);
          chk("rsp_flags", rsp_flags, e[3:0]);
        end
        rsp_cyc.push_back(cyc);
        n_rsp++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] cms [7];
    int lat, base, seen;
    cms = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd12};
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cm = '0;
    req_temp = '0; rsp_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
    clr_sticky = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("rst_alu_num1", alu_num1, 0);
    chk("rst_alu_cm", alu_cm, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);

    // Single request: latency and settle window
    push_req(32'h00011, 32'h00101, 4'd0, 2'd0);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      step(); lat++;
      if (lat >= 2 && lat <= SETTLE + 2) begin
        chk("settle_num1", alu_num1, 32'h00011);
        chk("settle_num2", alu_num2, 32'h00101);
      end
    end
    chk("latency", lat, SETTLE + 3);
    chk("single_result", rsp_result, 32'h00112);
    chk("single_flags", rsp_flags, 4'b0000);
    repeat (3) step();
    chk("hold_valid", rsp_valid, 1);
    chk("hold_result", rsp_result, 32'h00112);
    rsp_ready = 1'b1;
    drain();
    chk("alu_num1_retained", alu_num1, 32'h00011);

    // Back-to-back stream
    base = n_rsp; rsp_cyc.delete();
    for (int i = 0; i < 7; i++) push_req(32'h00011, 32'h00101, cms[i], 2'd0);
    drain();
    chk("stream_count", n_rsp - base, 7);
    for (int i = 1; i < rsp_cyc.size(); i++)
      chk("stream_gap", rsp_cyc[i] - rsp_cyc[i-1], SETTLE + 3);

    // Backpressure: 4 in FIFO plus 1 in the FSM, then blocked
    rsp_ready = 1'b0; base = n_rsp;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("bp_ready_before_5th", req_ready, 1);
      push_req(32'h100 + i, 32'h7, 4'd0, 2'(i));
    end
    chk("bp_ready_low", req_ready, 0);
    req_a = 32'h200; req_b = 32'h3; req_cm = 4'd1; req_temp = 2'd3; req_valid = 1'b1;
    repeat (4) step();
    chk("bp_still_blocked", req_ready, 0);
    rsp_ready = 1'b1;
    lat = 0;
    while (!req_ready && lat < 100) begin step(); lat++; end
    step();
    req_valid = 1'b0;
    drain();
    chk("bp_count", n_rsp - base, 6);

    // Simultaneous push and pop at 3/4 full
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req(32'hA0 + i, 32'h1, 4'd4, 2'd1);
    wait_rsp_valid();
    chk("pp_count_before", dut.fifo_count, 3);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    req_a = 32'hBEEF; req_b = 32'h1; req_cm = 4'd2; req_temp = 2'd2; req_valid = 1'b1;
    chk("pp_ready_before", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("pp_count", dut.fifo_count, 3);
    chk("pp_ready", req_ready, 1);
    rsp_ready = 1'b1;
    drain();

    // Reset during DRIVE with three requests queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_req(32'h5000 + i, 32'h1234, 4'd3, 2'd2);
    wait_rsp_valid();
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    step();
    chk("rst_mid_queued", dut.fifo_count, 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstmid_num1", alu_num1, 0);
    chk("rstmid_num2", alu_num2, 0);
    chk("rstmid_cm", alu_cm, 0);
    chk("rstmid_temp", alu_temp, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_rsp_result", rsp_result, 0);
    chk("rstmid_rsp_flags", rsp_flags, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_req_ready", req_ready, 1);
    rsp_ready = 1'b1; seen = 0;
    repeat (20) begin step(); if (rsp_valid) seen++; end
    chk("rstmid_no_rsp", seen, 0);

    // Pointer wrap with random traffic
    base = n_rsp;
    for (int i = 0; i < 12; i++)
      push_req($urandom, $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    drain();
    chk("wrap_count", n_rsp - base, 12);

`ifdef ALU_STICKY_FLAGS_EN
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("sticky_cleared", sticky_flags, 4'b0000);
    push_req(32'h1, 32'h1, 4'd15, 2'd0); drain();
    push_req(32'h2, 32'h8, 4'd15, 2'd0); drain();
    chk("sticky_or", sticky_flags, 4'b1001);
    rsp_ready = 1'b0;
    push_req(32'h3, 32'h4, 4'd15, 2'd0);
    repeat (SETTLE + 2) step();
    chk("sticky_pre_capture", rsp_valid, 0);
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("sticky_capture_valid", rsp_valid, 1);
    chk("sticky_clr_capture", sticky_flags, 4'b0100);
    rsp_ready = 1'b1;
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
